array_mac: RTL

ARRAY_MAC -- requirements
Module: array_mac

---
 rtl/array_mac_pkg.sv | 39 +++
 rtl/array_mac_lane.sv | 31 +++
 rtl/array_mac.sv | 172 +++++++++++++++++
 3 files changed

// File: rtl/array_mac_pkg.sv
// Shared types, default geometry and saturation limits for the array_mac datapath.
package array_mac_pkg;

  typedef enum logic [1:0] {
    MODE_MUL = 2'd0,
    MODE_DOT = 2'd1,
    MODE_MAC = 2'd2
  } mode_e;

  localparam int unsigned N_DEF    = 4;
  localparam int unsigned W_DEF    = 36;
  localparam int unsigned FRAC_DEF = 18;
  localparam int unsigned LAT_DEF  = 3;
  localparam int unsigned SAT_BITS = 128;

  function automatic logic signed [SAT_BITS-1:0] sat_max(input int unsigned w);
    logic signed [SAT_BITS-1:0] one;
    one    = '0;
    one[0] = 1'b1;
    return (one <<< (w - 1)) - one;
  endfunction

  function automatic logic signed [SAT_BITS-1:0] sat_min(input int unsigned w);
    logic signed [SAT_BITS-1:0] one;
    one    = '0;
    one[0] = 1'b1;
    return -(one <<< (w - 1));
  endfunction

  // Reserved encoding 3 folds onto MUL.
  function automatic mode_e decode_mode(input logic [1:0] m);
    case (m)
      2'd1:    return MODE_DOT;
      2'd2:    return MODE_MAC;
      default: return MODE_MUL;
    endcase
  endfunction

endpackage

// File: rtl/array_mac_lane.sv
// One lane: signed fixed-point multiply, floor shift by FRAC, clamp to W bits.
module array_mac_lane
  import array_mac_pkg::*;
#(
  parameter int unsigned W    = W_DEF,
  parameter int unsigned FRAC = FRAC_DEF
) (
  input  logic signed [W-1:0] a,
  input  logic signed [W-1:0] b,
  output logic signed [W-1:0] p,
  output logic                clamp
);
  localparam int unsigned PW = 2 * W;

  logic signed [PW-1:0] prod;
  logic signed [PW-1:0] shifted;
  logic signed [PW-1:0] hi;
  logic signed [PW-1:0] lo;

  always_comb begin
    hi      = PW'(sat_max(W));
    lo      = PW'(sat_min(W));
    prod    = PW'(a) * PW'(b);
    shifted = prod >>> FRAC;
    clamp   = (shifted > hi) || (shifted < lo);
    if (shifted > hi)      p = hi[W-1:0];
    else if (shifted < lo) p = lo[W-1:0];
    else                   p = shifted[W-1:0];
  end

endmodule

// File: rtl/array_mac.sv
// N-lane fixed-point MUL/DOT/MAC engine with valid/ready handshake and LAT-cycle latency.
module array_mac
  import array_mac_pkg::*;
#(
  parameter int unsigned N    = N_DEF,
  parameter int unsigned W    = W_DEF,
  parameter int unsigned FRAC = FRAC_DEF,
  parameter int unsigned LAT  = LAT_DEF
) (
  input  logic           clk,
  input  logic           rst,
  input  logic           in_valid,
  output logic           in_ready,
  input  logic [1:0]     mode,
  input  logic           last,
  input  logic [N*W-1:0] dataa,
  input  logic [N*W-1:0] datab,
  output logic           out_valid,
  input  logic           out_ready,
  output logic [N*W-1:0] result,
  output logic [N-1:0]   overflow
);
  localparam int unsigned DL = LAT - 1;
  localparam int unsigned SW = W + $clog2(N) + 1;
  localparam int unsigned AW = W + 1;

  logic           s1_valid_q, s1_valid_d;
  mode_e          s1_mode_q, s1_mode_d;
  logic           s1_last_q, s1_last_d;
  logic [N*W-1:0] s1_a_q, s1_a_d, s1_b_q, s1_b_d;

  logic           dl_valid_q [DL];
  logic           dl_valid_d [DL];
  logic [N*W-1:0] dl_res_q   [DL];
  logic [N*W-1:0] dl_res_d   [DL];
  logic [N-1:0]   dl_ovf_q   [DL];
  logic [N-1:0]   dl_ovf_d   [DL];

  logic signed [W-1:0] acc_q [N];
  logic signed [W-1:0] acc_d [N];
  logic [N-1:0]        sticky_q, sticky_d;

  logic signed [W-1:0]  lane_p [N];
  logic [N-1:0]         lane_clamp;
  logic signed [SW-1:0] dot_sum;
  logic                 dot_clamp;
  logic signed [W-1:0]  dot_val;
  logic signed [AW-1:0] add_sum;
  logic signed [W-1:0]  acc_next [N];
  logic [N-1:0]         add_clamp;
  logic [N*W-1:0]       res_new;
  logic [N-1:0]         ovf_new;
  logic                 emit;
  logic                 adv;

  for (genvar g = 0; g < N; g++) begin : g_lane
    array_mac_lane #(.W(W), .FRAC(FRAC)) u_lane (
      .a     (s1_a_q[g*W +: W]),
      .b     (s1_b_q[g*W +: W]),
      .p     (lane_p[g]),
      .clamp (lane_clamp[g])
    );
  end

  always_comb begin
    dot_sum = '0;
    for (int unsigned i = 0; i < N; i++) dot_sum = dot_sum + SW'(lane_p[i]);
    dot_clamp = (dot_sum > SW'(sat_max(W))) || (dot_sum < SW'(sat_min(W)));
    if (dot_clamp) dot_val = dot_sum[SW-1] ? W'(sat_min(W)) : W'(sat_max(W));
    else           dot_val = dot_sum[W-1:0];

    // One extra bit suffices for acc+p; sign disagreement in the top two bits means clamp.
    add_sum = '0;
    for (int unsigned i = 0; i < N; i++) begin
      add_sum      = AW'(acc_q[i]) + AW'(lane_p[i]);
      add_clamp[i] = add_sum[AW-1] != add_sum[AW-2];
      if (add_clamp[i]) acc_next[i] = add_sum[AW-1] ? W'(sat_min(W)) : W'(sat_max(W));
      else              acc_next[i] = add_sum[W-1:0];
    end

    res_new = '0;
    ovf_new = '0;
    emit    = 1'b1;
    case (s1_mode_q)
      MODE_DOT: begin
        res_new[W-1:0] = dot_val;
        ovf_new[0]     = (|lane_clamp) || dot_clamp;
      end
      MODE_MAC: begin
        for (int unsigned i = 0; i < N; i++) res_new[i*W +: W] = acc_next[i];
        ovf_new = sticky_q | lane_clamp | add_clamp;
        emit    = s1_last_q;
      end
      default: begin
        for (int unsigned i = 0; i < N; i++) res_new[i*W +: W] = lane_p[i];
        ovf_new = lane_clamp;
      end
    endcase
  end

  assign out_valid = dl_valid_q[DL-1];
  assign result    = dl_res_q[DL-1];
  assign overflow  = dl_ovf_q[DL-1];

  always_comb begin
    adv        = !out_valid || out_ready;
    in_ready   = adv && !rst;
    s1_valid_d = s1_valid_q;
    s1_mode_d  = s1_mode_q;
    s1_last_d  = s1_last_q;
    s1_a_d     = s1_a_q;
    s1_b_d     = s1_b_q;
    dl_valid_d = dl_valid_q;
    dl_res_d   = dl_res_q;
    dl_ovf_d   = dl_ovf_q;
    acc_d      = acc_q;
    sticky_d   = sticky_q;
    if (adv) begin
      s1_valid_d  = in_valid;
      s1_mode_d   = decode_mode(mode);
      s1_last_d   = last;
      s1_a_d      = dataa;
      s1_b_d      = datab;
      dl_valid_d[0] = s1_valid_q && emit;
      dl_res_d[0]   = res_new;
      dl_ovf_d[0]   = ovf_new;
      for (int unsigned k = 1; k < DL; k++) begin
        dl_valid_d[k] = dl_valid_q[k-1];
        dl_res_d[k]   = dl_res_q[k-1];
        dl_ovf_d[k]   = dl_ovf_q[k-1];
      end
      if (s1_valid_q && s1_mode_q == MODE_MAC) begin
        if (s1_last_q) begin
          acc_d    = '{default: '0};
          sticky_d = '0;
        end else begin
          acc_d    = acc_next;
          sticky_d = ovf_new;
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      s1_valid_q <= 1'b0;
      s1_mode_q  <= MODE_MUL;
      s1_last_q  <= 1'b0;
      s1_a_q     <= '0;
      s1_b_q     <= '0;
      for (int unsigned k = 0; k < DL; k++) begin
        dl_valid_q[k] <= 1'b0;
        dl_res_q[k]   <= '0;
        dl_ovf_q[k]   <= '0;
      end
      for (int unsigned i = 0; i < N; i++) acc_q[i] <= '0;
      sticky_q <= '0;
    end else begin
      s1_valid_q <= s1_valid_d;
      s1_mode_q  <= s1_mode_d;
      s1_last_q  <= s1_last_d;
      s1_a_q     <= s1_a_d;
      s1_b_q     <= s1_b_d;
      dl_valid_q <= dl_valid_d;
      dl_res_q   <= dl_res_d;
      dl_ovf_q   <= dl_ovf_d;
      acc_q      <= acc_d;
      sticky_q   <= sticky_d;
    end
  end

endmodule
